tradeoff_job_scheduler: RTL and testbench

- Upstream/downstream wrapper stage for the Tradeoff_16bits search core.
- Accepts a stream of W requests through a valid/ready input and buffers them in a small FIFO.
- Launches one search at a time on the core by driving core_w and pulsing core_restart.
- Waits for core_found, or for a timeout, then returns {W, N, timeout} on a valid/ready output.

---
 rtl/tradeoff_job_scheduler.sv | 176 +++++++++++++++++
 tb/tb_tradeoff_job_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tradeoff_job_scheduler.sv
// Job scheduler wrapped around the Tradeoff_16bits search core: queues W requests,
// runs them one at a time on the core and reports {W, N, timeout} downstream.
module tradeoff_job_scheduler #(
  parameter int W_BITS         = 30,
  parameter int N_BITS         = 17,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TO_BITS        = 18
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W_BITS-1:0]             in_w,
  output logic [W_BITS-1:0]             core_w,
  output logic                          core_restart,
  input  logic                          core_found,
  input  logic [N_BITS-1:0]             core_n,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [W_BITS-1:0]             out_w,
  output logic [N_BITS-1:0]             out_n,
  output logic                          out_timeout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [TO_BITS-1:0]  TIMER_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_FULL   = CNT_BITS'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    SETTLE = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t               state_r;
  logic [W_BITS-1:0]    fifo_mem_r [FIFO_DEPTH];
  logic [PTR_BITS-1:0]  rd_ptr_r;
  logic [PTR_BITS-1:0]  wr_ptr_r;
  logic [CNT_BITS-1:0]  count_r;
  logic [CNT_BITS-1:0]  count_next_s;
  logic [TO_BITS-1:0]   timer_r;
  logic                 in_ready_r;
  logic                 busy_r;
  logic                 core_restart_r;
  logic                 out_valid_r;
  logic                 out_timeout_r;
  logic [W_BITS-1:0]    core_w_r;
  logic [W_BITS-1:0]    out_w_r;
  logic [N_BITS-1:0]    out_n_r;
  logic                 push_s;
  logic                 pop_s;

  assign push_s = in_valid & in_ready_r;
  assign pop_s  = (state_r == IDLE) && (count_r != {CNT_BITS{1'b0}});

  // Next FIFO occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_BITS'(1);
      2'b01:   count_next_s = count_r - CNT_BITS'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Request FIFO storage, pointers, occupancy and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {W_BITS{1'b0}};
      end
      rd_ptr_r   <= {PTR_BITS{1'b0}};
      wr_ptr_r   <= {PTR_BITS{1'b0}};
      count_r    <= {CNT_BITS{1'b0}};
      in_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= in_w;
        wr_ptr_r             <= wr_ptr_r + PTR_BITS'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_BITS'(1);
      end
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s != CNT_FULL);
    end
  end

  // Job sequencing FSM with all core-facing and result outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      timer_r        <= {TO_BITS{1'b0}};
      busy_r         <= 1'b0;
      core_restart_r <= 1'b0;
      core_w_r       <= {W_BITS{1'b0}};
      out_valid_r    <= 1'b0;
      out_w_r        <= {W_BITS{1'b0}};
      out_n_r        <= {N_BITS{1'b0}};
      out_timeout_r  <= 1'b0;
    end else begin
      core_restart_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            core_w_r       <= fifo_mem_r[rd_ptr_r];
            out_w_r        <= fifo_mem_r[rd_ptr_r];
            core_restart_r <= 1'b1;
            busy_r         <= 1'b1;
            state_r        <= LAUNCH;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        LAUNCH: begin
          timer_r <= {TO_BITS{1'b0}};
          state_r <= WAIT;
        end
        WAIT: begin
          if (timer_r != TIMER_LAST) begin
            timer_r <= timer_r + TO_BITS'(1);
          end
          // timer_r == 0 marks the first WAIT cycle, where found may be stale.
          if (core_found && (timer_r != {TO_BITS{1'b0}})) begin
            state_r <= SETTLE;
          end else if (timer_r == TIMER_LAST) begin
            out_n_r       <= {N_BITS{1'b0}};
            out_timeout_r <= 1'b1;
            out_valid_r   <= 1'b1;
            state_r       <= HOLD;
          end else begin
            state_r <= WAIT;
          end
        end
        SETTLE: begin
          out_n_r       <= core_n;
          out_timeout_r <= 1'b0;
          out_valid_r   <= 1'b1;
          state_r       <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign core_w       = core_w_r;
  assign core_restart = core_restart_r;
  assign out_valid    = out_valid_r;
  assign out_w        = out_w_r;
  assign out_n        = out_n_r;
  assign out_timeout  = out_timeout_r;
  assign busy         = busy_r;
  assign fifo_count   = count_r;

endmodule

// File: tb/tb_tradeoff_job_scheduler.sv
// Directed bench for tradeoff_job_scheduler with a behavioural search core and a
// result scoreboard; W flag bits select the core behaviour for each job.
module tb_tradeoff_job_scheduler;

  localparam int W_BITS  = 30;
  localparam int N_BITS  = 17;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 50;
  localparam int TO_BITS = 18;
  localparam logic [W_BITS-1:0] TO_FLAG    = 30'h0010_0000;
  localparam logic [W_BITS-1:0] STALE_FLAG = 30'h0020_0000;

  typedef struct packed {
    logic [W_BITS-1:0] w;
    logic [N_BITS-1:0] n;
    logic              to;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [W_BITS-1:0]   in_w = '0;
  logic [W_BITS-1:0]   core_w;
  logic                core_restart;
  logic                core_found;
  logic [N_BITS-1:0]   core_n;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [W_BITS-1:0]   out_w;
  logic [N_BITS-1:0]   out_n;
  logic                out_timeout;
  logic                busy;
  logic [2:0]          fifo_count;

  int   checks = 0;
  int   errors = 0;
  int   restarts = 0;
  int   cyc = 0;
  int   launch_cyc = 0;
  int   r0;
  logic ov_prev = 1'b0;
  exp_t pend;
  exp_t sb[$];
  int   exp_cnt[5] = '{1, 1, 2, 3, 4};

  tradeoff_job_scheduler #(
    .W_BITS(W_BITS), .N_BITS(N_BITS), .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT), .TO_BITS(TO_BITS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w),
    .core_w(core_w), .core_restart(core_restart), .core_found(core_found),
    .core_n(core_n), .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w),
    .out_n(out_n), .out_timeout(out_timeout), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [N_BITS-1:0] model_n(input logic [W_BITS-1:0] w);
    logic [N_BITS-1:0] p;
    p = N_BITS'(w[3:0]) * 17'd13107;
    return p;
  endfunction

  function automatic exp_t expect_of(input logic [W_BITS-1:0] w);
    exp_t e;
    e.w  = w;
    e.to = ((w & TO_FLAG) != '0);
    if (e.to) e.n = '0;
    else if ((w & STALE_FLAG) != '0) e.n = 17'd123;
    else e.n = model_n(w);
    return e;
  endfunction

  // Behavioural core: found 10 cycles after restart; TO_FLAG jobs never finish;
  // STALE_FLAG jobs keep the previous found high for one extra cycle.
  int   core_cnt;
  logic core_armed, core_stale;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_found <= 1'b0; core_n <= '0; core_cnt <= 0;
      core_armed <= 1'b0; core_stale <= 1'b0;
    end else if (core_restart) begin
      core_armed <= ((core_w & TO_FLAG) == '0);
      core_cnt   <= 10;
      if ((core_w & STALE_FLAG) != '0) core_stale <= 1'b1;
      else core_found <= 1'b0;
    end else if (core_stale) begin
      core_found <= 1'b0;
      core_stale <= 1'b0;
    end else if (core_armed) begin
      if (core_cnt <= 1) begin
        core_found <= 1'b1;
        core_n     <= ((core_w & STALE_FLAG) != '0) ? 17'd123 : model_n(core_w);
        core_armed <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    if (!rst) begin
      if (core_restart) begin
        restarts++;
        launch_cyc = cyc;
      end
      if (out_valid && !ov_prev && sb.size() != 0 && sb[0].to)
        check("timeout_latency", 64'(cyc - launch_cyc), 64'(TIMEOUT + 1));
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        check("result_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_w", 64'(out_w), 64'(e.w));
          check("out_n", 64'(out_n), 64'(e.n));
          check("out_timeout", 64'(out_timeout), 64'(e.to));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(pend);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) in_valid = 1'b0;
  endtask

  task automatic start_push(input logic [W_BITS-1:0] w);
    in_w     = w;
    pend     = expect_of(w);
    in_valid = 1'b1;
  endtask

  task automatic push(input logic [W_BITS-1:0] w);
    start_push(w);
    for (int i = 0; i < 300 && in_valid; i++) tick();
    check("push_accepted", 64'(in_valid), 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && (sb.size() != 0 || in_valid); i++) tick();
    check("drain_done", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_core_w", 64'(core_w), 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Single job with latency of pop and restart pulse
    out_ready = 1'b1;
    r0 = restarts;
    start_push(30'd5);
    tick();
    check("t1_count_after_push", 64'(fifo_count), 64'd1);
    check("t1_restart_c0", 64'(core_restart), 64'd0);
    tick();
    check("t1_restart_c1", 64'(core_restart), 64'd1);
    check("t1_busy_c1", 64'(busy), 64'd1);
    check("t1_core_w", 64'(core_w), 64'd5);
    check("t1_count_after_pop", 64'(fifo_count), 64'd0);
    tick();
    check("t1_restart_c2", 64'(core_restart), 64'd0);
    drain();
    check("t1_one_restart", 64'(restarts - r0), 64'd1);
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_out_valid_after", 64'(out_valid), 64'd0);
    repeat (3) tick();

    // FIFO full under backpressure, then in-order drain
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(30'(i + 1));
      check("t2_fifo_count", 64'(fifo_count), 64'(exp_cnt[i]));
    end
    check("t2_full_in_ready", 64'(in_ready), 64'd0);
    start_push(30'd6);
    repeat (30) tick();
    check("t2_blocked", 64'(in_valid), 64'd1);
    check("t2_still_full", 64'(fifo_count), 64'd4);
    out_ready = 1'b1;
    drain();
    check("t2_empty", 64'(fifo_count), 64'd0);
    repeat (3) tick();

    // Stale found across restart; previous job left found high
    push(STALE_FLAG | 30'd4);
    drain();
    repeat (3) tick();

    // Timeout followed by a normal job
    push(TO_FLAG | 30'd9);
    push(30'd10);
    drain();
    repeat (3) tick();

    // Output backpressure for 20 cycles while the FIFO fills
    out_ready = 1'b0;
    push(30'd11);
    for (int i = 0; i < 100 && !out_valid; i++) tick();
    check("t5_out_valid", 64'(out_valid), 64'd1);
    r0 = restarts;
    for (int i = 0; i < 20; i++) begin
      if (i < 4) start_push(30'(12 + i));
      tick();
      check("t5_hold_valid", 64'(out_valid), 64'd1);
      check("t5_hold_w", 64'(out_w), 64'd11);
      check("t5_hold_n", 64'(out_n), 64'(model_n(30'd11)));
      check("t5_hold_to", 64'(out_timeout), 64'd0);
    end
    check("t5_no_restart", 64'(restarts - r0), 64'd0);
    check("t5_fifo_full", 64'(fifo_count), 64'd4);
    check("t5_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    drain();
    repeat (3) tick();

    // Asynchronous reset in the middle of WAIT
    push(30'd20);
    repeat (4) tick();
    check("t6_busy_pre", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_core_w", 64'(core_w), 64'd0);
    check("t6_rst_restart", 64'(core_restart), 64'd0);
    check("t6_rst_in_ready", 64'(in_ready), 64'd1);
    check("t6_rst_out_wnt", 64'({out_w, out_n, out_timeout}), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ov_prev = 1'b0;
    r0 = restarts;
    repeat (30) tick();
    check("t6_silent", 64'(restarts - r0), 64'd0);
    push(30'd7);
    drain();
    check("t6_busy_after", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
